// File: rtl/bcd_display_driver.sv
// Signed binary to 7-segment display driver. Converts |value| to BCD with
// double dabble (one bit per cycle), then drives seven digits plus a sign.
module bcd_display_driver #(
  parameter int WIDTH   = 32,
  parameter int BCD_DIG = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [0:6]       HEX0,
  output logic [0:6]       HEX1,
  output logic [0:6]       HEX2,
  output logic [0:6]       HEX3,
  output logic [0:6]       HEX4,
  output logic [0:6]       HEX5,
  output logic [0:6]       HEX6,
  output logic [0:6]       HEX7
);

  localparam int CW     = $clog2(WIDTH + 1);
  localparam int SHOWN  = 7;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CONV, DISP} state_t;

  state_t                 state, state_nxt;
  logic                   sign;
  logic [WIDTH-1:0]       mag;
  logic [4*BCD_DIG-1:0]   bcd;
  logic [4*BCD_DIG-1:0]   bcd_adj;
  logic [CW-1:0]          cnt;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0001100;
      default: seg7 = 7'b0110000;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CONV;
      CONV:    if (cnt == LAST) state_nxt = DISP;
      DISP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Add-3 correction applied before each shift so nibbles stay decimal.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < BCD_DIG; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sign     <= 1'b0;
      mag      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
      HEX0     <= 7'b0000001;
      HEX1     <= 7'b0000001;
      HEX2     <= 7'b0000001;
      HEX3     <= 7'b0000001;
      HEX4     <= 7'b0000001;
      HEX5     <= 7'b0000001;
      HEX6     <= 7'b0000001;
      HEX7     <= 7'b1111111;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign <= value[WIDTH-1];
            mag  <= value[WIDTH-1] ? -value : value;
            bcd  <= '0;
            cnt  <= '0;
          end
        end
        CONV: begin
          bcd <= {bcd_adj[4*BCD_DIG-2:0], mag[WIDTH-1]};
          mag <= {mag[WIDTH-2:0], 1'b0};
          cnt <= cnt + 1'b1;
        end
        DISP: begin
          HEX0     <= seg7(bcd[3:0]);
          HEX1     <= seg7(bcd[7:4]);
          HEX2     <= seg7(bcd[11:8]);
          HEX3     <= seg7(bcd[15:12]);
          HEX4     <= seg7(bcd[19:16]);
          HEX5     <= seg7(bcd[23:20]);
          HEX6     <= seg7(bcd[27:24]);
          HEX7     <= sign ? 7'b1111110 : 7'b1111111;
          // Digits above the millions place cannot be shown; flag them instead.
          overflow <= |bcd[4*BCD_DIG-1:4*SHOWN];
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
